// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch
// and the data stage. One transfer in flight at a time; data side wins ties
// except that fetch is forced through after MAX_DM back-to-back data grants.
// Every output comes from a flop, so no input reaches an output combinationally.
module mem_port_arbiter #(
  parameter int WIDTH  = 32,
  parameter int MAX_DM = 3
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             if_req_in,
  input  logic [WIDTH-1:0] if_addr_in,
  output logic             if_gnt_out,
  output logic             if_valid_out,
  output logic [WIDTH-1:0] if_data_out,
  input  logic             dm_req_in,
  input  logic             dm_we_in,
  input  logic [WIDTH-1:0] dm_addr_in,
  input  logic [WIDTH-1:0] dm_wdata_in,
  output logic             dm_gnt_out,
  output logic             dm_valid_out,
  output logic [WIDTH-1:0] dm_rdata_out,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [WIDTH-1:0] mem_addr_out,
  output logic [WIDTH-1:0] mem_wdata_out,
  input  logic [WIDTH-1:0] mem_rdata_in,
  input  logic             mem_ack_in,
  output logic             busy_out
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  // The streak counter is 4 bits wide, so MAX_DM is capped at 15.
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM);

  state_t     state, state_nxt;
  logic [3:0] streak, streak_nxt;
  logic       win_if, win_dm;
  logic       done_if, done_dm;

  // State and starvation counter.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Next state: leave IDLE on a grant, return to IDLE on acknowledge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (win_dm)      state_nxt = DM_BUSY;
        else if (win_if) state_nxt = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: if (mem_ack_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration, completion decode and streak update.
  // Data wins unless fetch is waiting and the data streak hit its limit.
  // The streak only grows while fetch is actually being held off.
  always_comb begin
    win_if     = 1'b0;
    win_dm     = 1'b0;
    done_if    = (state == IF_BUSY) && mem_ack_in;
    done_dm    = (state == DM_BUSY) && mem_ack_in;
    streak_nxt = streak;
    if (state == IDLE) begin
      if (dm_req_in && !(if_req_in && streak == STREAK_MAX)) win_dm = 1'b1;
      else if (if_req_in)                                     win_if = 1'b1;
    end
    if (win_if)
      streak_nxt = '0;
    else if (win_dm)
      streak_nxt = !if_req_in ? 4'd0 :
                   (streak == STREAK_MAX) ? streak : streak + 4'd1;
  end

  // Registered handshake pulses, memory command and returned data.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      if_gnt_out    <= 1'b0;
      dm_gnt_out    <= 1'b0;
      if_valid_out  <= 1'b0;
      dm_valid_out  <= 1'b0;
      if_data_out   <= '0;
      dm_rdata_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      if_gnt_out   <= win_if;
      dm_gnt_out   <= win_dm;
      if_valid_out <= done_if;
      dm_valid_out <= done_dm;
      // Write data is captured on every grant; on a fetch it is unused.
      if (win_dm) begin
        mem_we_out    <= dm_we_in;
        mem_addr_out  <= dm_addr_in;
        mem_wdata_out <= dm_wdata_in;
      end else if (win_if) begin
        mem_we_out    <= 1'b0;
        mem_addr_out  <= if_addr_in;
        mem_wdata_out <= dm_wdata_in;
      end
      if (done_if)                dm_rdata_out <= dm_rdata_out;
      if (done_if)                if_data_out  <= mem_rdata_in;
      // Stores complete without disturbing the last load result.
      if (done_dm && !mem_we_out) dm_rdata_out <= mem_rdata_in;
    end
  end

  // The request is held for exactly the BUSY states.
  assign busy_out    = (state != IDLE);
  assign mem_req_out = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (instantiated with MAX_DM = 2).
module tb_mem_port_arbiter;

  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic         if_req_in, dm_req_in, dm_we_in, mem_ack_in;
  logic [W-1:0] if_addr_in, dm_addr_in, dm_wdata_in, mem_rdata_in;
  logic         if_gnt_out, if_valid_out, dm_gnt_out, dm_valid_out;
  logic         mem_req_out, mem_we_out, busy_out;
  logic [W-1:0] if_data_out, dm_rdata_out, mem_addr_out, mem_wdata_out;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_port_arbiter #(.WIDTH(W), .MAX_DM(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_gnt_out(if_gnt_out), .if_valid_out(if_valid_out), .if_data_out(if_data_out),
    .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_addr_in(dm_addr_in),
    .dm_wdata_in(dm_wdata_in), .dm_gnt_out(dm_gnt_out), .dm_valid_out(dm_valid_out),
    .dm_rdata_out(dm_rdata_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in), .busy_out(busy_out)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_in = 1'b0; if_req_in = 0; dm_req_in = 0; dm_we_in = 0; mem_ack_in = 0;
    if_addr_in = '0; dm_addr_in = '0; dm_wdata_in = '0; mem_rdata_in = '0;
    step(); step();
    chk("rst_busy", W'(busy_out), 0);
    chk("rst_memreq", W'(mem_req_out), 0);
    chk("rst_gnt", W'({if_gnt_out, dm_gnt_out}), 0);
    chk("rst_vld", W'({if_valid_out, dm_valid_out}), 0);
    chk("rst_addr", mem_addr_out, 0);
    chk("rst_data", if_data_out | dm_rdata_out | mem_wdata_out, 0);
    rst_in = 1'b1;
    step();

    // Single fetch, ack in the third busy cycle.
    if_req_in = 1; if_addr_in = 32'h40;
    step();
    chk("f_gnt", W'(if_gnt_out), 1);
    chk("f_dmgnt", W'(dm_gnt_out), 0);
    chk("f_req1", W'(mem_req_out), 1);
    chk("f_addr", mem_addr_out, 32'h40);
    chk("f_we", W'(mem_we_out), 0);
    if_req_in = 0;
    step();
    chk("f_gnt_pulse", W'(if_gnt_out), 0);
    chk("f_req2", W'(mem_req_out), 1);
    step();
    chk("f_req3", W'(mem_req_out), 1);
    chk("f_vld_early", W'(if_valid_out), 0);
    mem_ack_in = 1; mem_rdata_in = 32'h00500093;
    step();
    chk("f_vld", W'(if_valid_out), 1);
    chk("f_data", if_data_out, 32'h00500093);
    chk("f_req_off", W'(mem_req_out), 0);
    chk("f_busy_off", W'(busy_out), 0);
    mem_ack_in = 0;
    step();
    chk("f_vld_pulse", W'(if_valid_out), 0);

    // Collision: data load wins, fetch follows after the data transfer.
    if_req_in = 1; if_addr_in = 32'h44;
    dm_req_in = 1; dm_we_in = 0; dm_addr_in = 32'h100;
    step();
    chk("c_dmgnt", W'(dm_gnt_out), 1);
    chk("c_ifgnt", W'(if_gnt_out), 0);
    chk("c_addr", mem_addr_out, 32'h100);
    dm_req_in = 0;
    mem_ack_in = 1; mem_rdata_in = 32'h11111111;
    step();
    chk("c_dmvld", W'(dm_valid_out), 1);
    chk("c_dmdata", dm_rdata_out, 32'h11111111);
    chk("c_ifgnt_wait", W'(if_gnt_out), 0);
    mem_ack_in = 0;
    step();
    chk("c_ifgnt2", W'(if_gnt_out), 1);
    chk("c_addr2", mem_addr_out, 32'h44);
    if_req_in = 0;
    mem_ack_in = 1; mem_rdata_in = 32'h22220000;
    step();
    chk("c_ifvld", W'(if_valid_out), 1);
    chk("c_ifdata", if_data_out, 32'h22220000);
    chk("c_dmdata_keep", dm_rdata_out, 32'h11111111);
    mem_ack_in = 0;
    step();

    // Store: load data register must not change.
    dm_req_in = 1; dm_we_in = 1; dm_addr_in = 32'h20; dm_wdata_in = 32'hDEADBEEF;
    step();
    chk("s_gnt", W'(dm_gnt_out), 1);
    chk("s_we", W'(mem_we_out), 1);
    chk("s_addr", mem_addr_out, 32'h20);
    chk("s_wdata", mem_wdata_out, 32'hDEADBEEF);
    dm_req_in = 0; dm_we_in = 0;
    step();
    chk("s_we_hold", W'(mem_we_out), 1);
    mem_ack_in = 1; mem_rdata_in = 32'hCAFEF00D;
    step();
    chk("s_vld", W'(dm_valid_out), 1);
    chk("s_rdata_keep", dm_rdata_out, 32'h11111111);
    mem_ack_in = 0;
    step();
    chk("s_vld_pulse", W'(dm_valid_out), 0);

    // Starvation bound + minimum latency: both requests held, ack held high.
    // Expected grants with limit 2: D D I D D I, each transfer taking 2 cycles.
    begin
      logic [5:0] exp_if;
      exp_if = 6'b100100;
      if_req_in = 1; dm_req_in = 1; dm_we_in = 0; mem_ack_in = 1; mem_rdata_in = 32'h33333333;
      for (int i = 0; i < 6; i++) begin
        step();
        chk($sformatf("st_ifgnt%0d", i), W'(if_gnt_out), W'(exp_if[i]));
        chk($sformatf("st_dmgnt%0d", i), W'(dm_gnt_out), W'(!exp_if[i]));
        step();
        chk($sformatf("st_ifvld%0d", i), W'(if_valid_out), W'(exp_if[i]));
        chk($sformatf("st_dmvld%0d", i), W'(dm_valid_out), W'(!exp_if[i]));
        chk($sformatf("st_idle%0d", i), W'(busy_out), 0);
      end
      chk("st_dmdata", dm_rdata_out, 32'h33333333);
    end

    // Ack while IDLE with no request is ignored.
    if_req_in = 0; dm_req_in = 0; mem_ack_in = 1;
    step(); step();
    chk("idle_ack_vld", W'({if_valid_out, dm_valid_out}), 0);
    chk("idle_ack_busy", W'(busy_out), 0);
    mem_ack_in = 0;
    step();

    // Reset in the second DM_BUSY cycle, late ack afterwards.
    dm_req_in = 1; dm_addr_in = 32'h80;
    step();
    chk("r_gnt", W'(dm_gnt_out), 1);
    dm_req_in = 0;
    step();
    chk("r_busy2", W'(busy_out), 1);
    rst_in = 0;
    step();
    chk("r_memreq", W'(mem_req_out), 0);
    chk("r_busy", W'(busy_out), 0);
    chk("r_vld", W'(dm_valid_out), 0);
    chk("r_addr_clr", mem_addr_out, 0);
    rst_in = 1; mem_ack_in = 1; mem_rdata_in = 32'h44444444;
    step();
    chk("r_late_vld", W'(dm_valid_out), 0);
    mem_ack_in = 0;
    step();
    chk("r_late_vld2", W'(dm_valid_out), 0);
    chk("r_rdata_clr", dm_rdata_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
